// File: rtl/rifl_tx_pkg.sv
// Shared frame codes and controller state type for the RIFL transmit path.
package rifl_tx_pkg;

  // Frame type codes; pairwise Hamming distance >= 6 so a few bit errors
  // on the link cannot turn one frame type into another.
  localparam logic [17:0] CODE_INIT    = 18'h2AAAA;
  localparam logic [17:0] CODE_IDLE    = 18'h15555;
  localparam logic [17:0] CODE_DATA    = 18'h3C3C3;
  localparam logic [17:0] CODE_PAUSE   = 18'h0F0F0;
  localparam logic [17:0] CODE_RESUME  = 18'h30F0F;
  localparam logic [17:0] CODE_RETRANS = 18'h03FFC;

  typedef enum logic [1:0] {
    INIT,
    NORMAL,
    REPLAY
  } tx_state_t;

endpackage

// File: rtl/rifl_tx_replay_buf.sv
// Go-back-N replay store: one word {tlast, tkeep, tdata} per frame id.
// Synchronous write, asynchronous read so the replay slot can emit the
// stored payload in the same cycle its id is selected.
module rifl_tx_replay_buf #(
  parameter int WORD_W = 271,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [2**ADDR_W];

  // Store each newly transmitted payload at its frame id.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rifl_tx_controller.sv
// RIFL transmit link controller: picks the type of every outgoing frame
// slot, keeps unacknowledged payloads for go-back-N replay and services
// remote retransmit/pause requests and local flow control.
module rifl_tx_controller
  import rifl_tx_pkg::*;
#(
  parameter int PAYLOAD_WIDTH  = 240,
  parameter int FRAME_ID_WIDTH = 8,
  parameter int CODE_WIDTH     = 18
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PAYLOAD_WIDTH-1:0]   s_axis_tdata,
  input  logic [PAYLOAD_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                       s_axis_tlast,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       rx_up,
  input  logic                       rx_error,
  input  logic [FRAME_ID_WIDTH-1:0]  rx_expected_id,
  input  logic                       retrans_req,
  input  logic [FRAME_ID_WIDTH-1:0]  retrans_id,
  input  logic                       ack_valid,
  input  logic [FRAME_ID_WIDTH-1:0]  ack_id,
  input  logic                       pause_req,
  input  logic                       local_fc,
  input  logic                       remote_fc,
  output logic [CODE_WIDTH-1:0]      frame_code,
  output logic [FRAME_ID_WIDTH-1:0]  frame_id,
  output logic [PAYLOAD_WIDTH-1:0]   frame_payload,
  output logic [PAYLOAD_WIDTH/8-1:0] frame_keep,
  output logic                       frame_last,
  output logic                       retrans_bad
);

  localparam int KW     = PAYLOAD_WIDTH / 8;
  localparam int FW     = FRAME_ID_WIDTH;
  localparam int PW     = FRAME_ID_WIDTH + 1;
  localparam int WORD_W = PAYLOAD_WIDTH + KW + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {FW{1'b0}}};

  tx_state_t          state_q, state_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      ack_ptr_q;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic               rx_error_q;
  logic               fc_sent_q, fc_sent_d;
  logic [CODE_WIDTH-1:0]    code_q, code_d;
  logic [FW-1:0]            id_q, id_d;
  logic [PAYLOAD_WIDTH-1:0] pay_q, pay_d;
  logic [KW-1:0]            keep_q, keep_d;
  logic                     last_q, last_d;
  logic                     bad_q;

  logic [PW-1:0]     count, ack_new, count_ack;
  logic [FW-1:0]     ack_diff, rt_diff;
  logic              full, ack_ok, rt_hit, link_act, rt_ok, rt_bad;
  logic              err_rise, fc_edge, hold;
  logic              buf_we;
  logic [WORD_W-1:0] rd_word;

  // Window bookkeeping; the ack is applied before a same-cycle retransmit
  // request is validated, while full uses the count before the ack.
  assign count     = wr_ptr_q - ack_ptr_q;
  assign full      = (count == DEPTH);
  assign ack_diff  = ack_id - ack_ptr_q[FW-1:0];
  assign ack_ok    = ack_valid && ({1'b0, ack_diff} <= count);
  assign ack_new   = ack_ok ? ack_ptr_q + {1'b0, ack_diff} : ack_ptr_q;
  assign count_ack = wr_ptr_q - ack_new;
  assign rt_diff   = retrans_id - ack_new[FW-1:0];
  assign rt_hit    = ({1'b0, rt_diff} < count_ack);

  assign link_act  = rx_up && (state_q != INIT);
  assign rt_ok     = retrans_req && link_act && rt_hit;
  assign rt_bad    = retrans_req && link_act && !rt_hit;
  assign err_rise  = rx_error && !rx_error_q;
  // A flow-control change stays pending until announced, so it is only
  // delayed (never lost) when a RETRANS frame takes the same slot.
  assign fc_edge   = (local_fc != fc_sent_q);
  assign hold      = pause_req || remote_fc;

  assign s_axis_tready = link_act && (state_q == NORMAL) && !full &&
                         !err_rise && !fc_edge && !hold;

  rifl_tx_replay_buf #(
    .WORD_W (WORD_W),
    .ADDR_W (FW)
  ) u_replay_buf (
    .clk_i   (clk),
    .we_i    (buf_we),
    .waddr_i (wr_ptr_q[FW-1:0]),
    .wdata_i ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .raddr_i (rd_ptr_q[FW-1:0]),
    .rdata_o (rd_word)
  );

  // Slot decision: frame type, pointer moves and next state.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fc_sent_d = fc_sent_q;
    buf_we    = 1'b0;
    code_d    = CODE_WIDTH'(CODE_IDLE);
    id_d      = '0;
    pay_d     = '0;
    keep_d    = '0;
    last_d    = 1'b0;

    if (!rx_up) begin
      code_d  = CODE_WIDTH'(CODE_INIT);
      state_d = INIT;
    end else if (state_q == INIT) begin
      code_d  = CODE_WIDTH'(CODE_INIT);
      state_d = (count_ack != '0) ? REPLAY : NORMAL;
    end else if (err_rise) begin
      code_d = CODE_WIDTH'(CODE_RETRANS);
      pay_d  = PAYLOAD_WIDTH'(rx_expected_id);
    end else if (fc_edge) begin
      code_d    = local_fc ? CODE_WIDTH'(CODE_PAUSE) : CODE_WIDTH'(CODE_RESUME);
      fc_sent_d = local_fc;
    end else if (hold) begin
      code_d = CODE_WIDTH'(CODE_IDLE);
    end else if (state_q == REPLAY) begin
      if (rd_ptr_q != wr_ptr_q) begin
        code_d   = CODE_WIDTH'(CODE_DATA);
        id_d     = rd_ptr_q[FW-1:0];
        pay_d    = rd_word[PAYLOAD_WIDTH-1:0];
        keep_d   = rd_word[PAYLOAD_WIDTH +: KW];
        last_d   = rd_word[WORD_W-1];
        rd_ptr_d = rd_ptr_q + 1'b1;
        if (rd_ptr_q + 1'b1 == wr_ptr_q) state_d = NORMAL;
      end else begin
        // An ack consumed everything still queued for replay.
        state_d = NORMAL;
      end
    end else if (s_axis_tvalid && !full) begin
      buf_we   = 1'b1;
      code_d   = CODE_WIDTH'(CODE_DATA);
      id_d     = wr_ptr_q[FW-1:0];
      pay_d    = s_axis_tdata;
      keep_d   = s_axis_tkeep;
      last_d   = s_axis_tlast;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (rt_ok) begin
      rd_ptr_d = ack_new + {1'b0, rt_diff};
      state_d  = REPLAY;
    end
    // Never replay a frame the remote has already acknowledged.
    if ((rd_ptr_d - ack_ptr_q) < (ack_new - ack_ptr_q)) rd_ptr_d = ack_new;
    // After a link drop, everything unacknowledged is replayed on relink.
    if (!rx_up) rd_ptr_d = ack_new;
  end

  // Controller state and registered frame outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= INIT;
      wr_ptr_q   <= '0;
      ack_ptr_q  <= '0;
      rd_ptr_q   <= '0;
      rx_error_q <= 1'b0;
      fc_sent_q  <= 1'b0;
      code_q     <= CODE_WIDTH'(CODE_INIT);
      id_q       <= '0;
      pay_q      <= '0;
      keep_q     <= '0;
      last_q     <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      ack_ptr_q  <= ack_new;
      rd_ptr_q   <= rd_ptr_d;
      rx_error_q <= rx_error;
      fc_sent_q  <= fc_sent_d;
      code_q     <= code_d;
      id_q       <= id_d;
      pay_q      <= pay_d;
      keep_q     <= keep_d;
      last_q     <= last_d;
      bad_q      <= rt_bad;
    end
  end

  assign frame_code    = code_q;
  assign frame_id      = id_q;
  assign frame_payload = pay_q;
  assign frame_keep    = keep_q;
  assign frame_last    = last_q;
  assign retrans_bad   = bad_q;

endmodule

// File: tb/tb_rifl_tx_controller.sv
// Randomized bench for rifl_tx_controller with a behavioural link model.
module tb_rifl_tx_controller;
  import rifl_tx_pkg::*;

  localparam int PW  = 240;
  localparam int FW  = 8;
  localparam int CW  = 18;
  localparam int KW  = PW / 8;
  localparam int NID = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tlast, s_axis_tvalid, s_axis_tready;
  logic          rx_up, rx_error;
  logic [FW-1:0] rx_expected_id;
  logic          retrans_req;
  logic [FW-1:0] retrans_id;
  logic          ack_valid;
  logic [FW-1:0] ack_id;
  logic          pause_req, local_fc, remote_fc;
  logic [CW-1:0] frame_code;
  logic [FW-1:0] frame_id;
  logic [PW-1:0] frame_payload;
  logic [KW-1:0] frame_keep;
  logic          frame_last, retrans_bad;

  always #5 clk = ~clk;

  rifl_tx_controller #(.PAYLOAD_WIDTH(PW), .FRAME_ID_WIDTH(FW), .CODE_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .rx_up(rx_up), .rx_error(rx_error), .rx_expected_id(rx_expected_id),
    .retrans_req(retrans_req), .retrans_id(retrans_id),
    .ack_valid(ack_valid), .ack_id(ack_id),
    .pause_req(pause_req), .local_fc(local_fc), .remote_fc(remote_fc),
    .frame_code(frame_code), .frame_id(frame_id), .frame_payload(frame_payload),
    .frame_keep(frame_keep), .frame_last(frame_last), .retrans_bad(retrans_bad)
  );

  int n_cmp = 0;
  int n_err = 0;
  int acc_cnt = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: unbounded integer sequence numbers and a payload
  // history indexed by id; the link is either down, streaming or replaying.
  int            m_wr, m_ack, m_rd;
  bit            m_linked, m_replay, m_err_prev, m_fc_told;
  logic [PW-1:0] m_data [NID];
  logic [KW-1:0] m_keep [NID];
  logic          m_last [NID];

  function automatic int md(input int x);
    return ((x % NID) + NID) % NID;
  endfunction

  function automatic logic [PW-1:0] rand_payload();
    logic [PW-1:0] p = '0;
    for (int i = 0; i < 8; i++) p = (p << 32) | PW'($urandom);
    return p;
  endfunction

  task automatic new_beat();
    s_axis_tdata = rand_payload();
    s_axis_tkeep = KW'({$urandom, $urandom});
    s_axis_tlast = 1'($urandom);
  endtask

  task automatic model_reset();
    m_wr = 0; m_ack = 0; m_rd = 0;
    m_linked = 0; m_replay = 0; m_err_prev = 0; m_fc_told = 0;
  endtask

  // One frame slot: predict, check tready, clock, check frame outputs.
  task automatic tick();
    int cnt, new_ack, d, old_wr;
    bit rise, fcch, hold, up, rdy, bad;
    logic [CW-1:0] e_code;
    logic [FW-1:0] e_id;
    logic [PW-1:0] e_pay;
    logic [KW-1:0] e_keep;
    logic          e_last;
    cnt = m_wr - m_ack;
    old_wr = m_wr;
    new_ack = m_ack;
    if (ack_valid) begin
      d = md(int'(ack_id) - m_ack);
      if (d <= cnt) new_ack = m_ack + d;
    end
    up   = rx_up && m_linked;
    rise = rx_error && !m_err_prev;
    fcch = (local_fc != m_fc_told);
    hold = pause_req || remote_fc;
    rdy  = up && !m_replay && (cnt < NID) && !rise && !fcch && !hold;
    e_code = CODE_IDLE; e_id = '0; e_pay = '0; e_keep = '0; e_last = 1'b0; bad = 0;
    if (!rx_up) begin
      e_code = CODE_INIT; m_linked = 0; m_replay = 0;
    end else if (!m_linked) begin
      e_code = CODE_INIT; m_linked = 1; m_replay = (m_wr != new_ack);
    end else if (rise) begin
      e_code = CODE_RETRANS; e_pay = PW'(rx_expected_id);
    end else if (fcch) begin
      e_code = local_fc ? CODE_PAUSE : CODE_RESUME; m_fc_told = local_fc;
    end else if (hold) begin
      e_code = CODE_IDLE;
    end else if (m_replay) begin
      if (m_rd < m_wr) begin
        e_code = CODE_DATA; e_id = FW'(md(m_rd));
        e_pay = m_data[md(m_rd)]; e_keep = m_keep[md(m_rd)]; e_last = m_last[md(m_rd)];
        m_rd++;
        if (m_rd == m_wr) m_replay = 0;
      end else m_replay = 0;
    end else if (s_axis_tvalid && cnt < NID) begin
      e_code = CODE_DATA; e_id = FW'(md(m_wr));
      e_pay = s_axis_tdata; e_keep = s_axis_tkeep; e_last = s_axis_tlast;
      m_data[md(m_wr)] = s_axis_tdata; m_keep[md(m_wr)] = s_axis_tkeep;
      m_last[md(m_wr)] = s_axis_tlast;
      m_wr++;
    end
    if (up && retrans_req) begin
      d = md(int'(retrans_id) - new_ack);
      if (d < old_wr - new_ack) begin m_rd = new_ack + d; m_replay = 1; end
      else bad = 1;
    end
    if (m_rd < new_ack) m_rd = new_ack;
    if (!rx_up) m_rd = new_ack;
    m_ack = new_ack;
    m_err_prev = rx_error;

    #1;
    chk("tready", s_axis_tready, rdy);
    if (s_axis_tready && s_axis_tvalid) acc_cnt++;
    @(posedge clk); #1;
    chk("code", frame_code, e_code);
    chk("id", frame_id, e_id);
    chk("payload", frame_payload, e_pay);
    chk("keep", frame_keep, e_keep);
    chk("last", frame_last, e_last);
    chk("retrans_bad", retrans_bad, bad);
    ack_valid = 1'b0;
    retrans_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rx_up = 0; rx_error = 0; rx_expected_id = '0; retrans_req = 0; retrans_id = '0;
    ack_valid = 0; ack_id = '0; pause_req = 0; local_fc = 0; remote_fc = 0;
    s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_code", frame_code, CODE_INIT);
    chk("rst_id", frame_id, 0);
    chk("rst_payload", frame_payload, 0);
    chk("rst_keep", frame_keep, 0);
    chk("rst_last", frame_last, 0);
    chk("rst_bad", retrans_bad, 0);
    chk("rst_tready", s_axis_tready, 0);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int down_cnt;
    // Link down, then fill the whole replay window without acks.
    do_reset();
    repeat (10) begin s_axis_tvalid = 1'($urandom); new_beat(); tick(); end
    rx_up = 1; s_axis_tvalid = 1;
    acc_cnt = 0;
    repeat (302) begin new_beat(); tick(); end
    chk("accepted_until_full", acc_cnt, 256);
    ack_valid = 1; ack_id = 8'd16;
    tick();
    repeat (20) begin new_beat(); tick(); end

    // Out-of-window and in-window retransmit, then error/flow-control.
    do_reset();
    rx_up = 1; tick();
    s_axis_tvalid = 1;
    repeat (10) begin new_beat(); tick(); end
    s_axis_tvalid = 0;
    ack_valid = 1; ack_id = 8'd2; tick();
    retrans_req = 1; retrans_id = 8'd20; tick();
    retrans_req = 1; retrans_id = 8'd5; tick();
    s_axis_tvalid = 1;
    repeat (12) begin new_beat(); tick(); end
    local_fc = 1; rx_error = 1; rx_expected_id = 8'h5A;
    repeat (4) begin new_beat(); tick(); end
    local_fc = 0; rx_error = 0;
    repeat (3) begin new_beat(); tick(); end
    pause_req = 1; repeat (2) begin new_beat(); tick(); end
    pause_req = 0; remote_fc = 1; repeat (2) begin new_beat(); tick(); end
    remote_fc = 0; repeat (2) begin new_beat(); tick(); end

    // Link drop in the middle of a replay, then relink.
    do_reset();
    rx_up = 1; tick();
    s_axis_tvalid = 1;
    repeat (10) begin new_beat(); tick(); end
    s_axis_tvalid = 0;
    ack_valid = 1; ack_id = 8'd4; tick();
    retrans_req = 1; retrans_id = 8'd4; tick();
    repeat (4) tick();
    rx_up = 0; repeat (3) tick();
    rx_up = 1; repeat (10) tick();

    // Long randomized run.
    down_cnt = 0;
    repeat (4000) begin
      s_axis_tvalid = ($urandom_range(0, 99) < 70);
      new_beat();
      if (down_cnt > 0) begin
        down_cnt--;
        rx_up = (down_cnt == 0);
      end else if ($urandom_range(0, 299) == 0) begin
        rx_up = 0; down_cnt = $urandom_range(1, 5);
      end
      if ($urandom_range(0, 29) == 0) rx_error = ~rx_error;
      if ($urandom_range(0, 24) == 0) local_fc = ~local_fc;
      if ($urandom_range(0, 19) == 0) pause_req = ~pause_req;
      if ($urandom_range(0, 29) == 0) remote_fc = ~remote_fc;
      rx_expected_id = FW'($urandom);
      if ($urandom_range(0, 99) < 15) begin
        ack_valid = 1;
        ack_id = FW'(m_ack + int'($urandom_range(0, (m_wr - m_ack) + 4)));
      end
      if ($urandom_range(0, 99) < 4) begin
        retrans_req = 1;
        retrans_id = FW'(m_ack + int'($urandom_range(0, (m_wr - m_ack) + 3)));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rifl_tx_controller.md
Name: rifl_tx_controller

Overview:
- Transmit-side link controller; the counterpart of the RX control path (aligner, CRC check, code decoder).
- Runs once per frame slot in the TX frame clock domain and decides each outgoing frame's type: INIT, IDLE, DATA, PAUSE, RESUME or RETRANS.
- Keeps a go-back-N replay buffer of unacknowledged payloads and services remote retransmit/pause requests plus local flow control.
- Feeds the TX scrambler/CRC stage; that stage handles the frame_code, frame_id and payload fields.

Parameters:
- PAYLOAD_WIDTH, 240, user payload bits per frame.
- FRAME_ID_WIDTH, 8, frame sequence number width; replay depth is 2**FRAME_ID_WIDTH.
- CODE_WIDTH, 18, frame type code width (matches the RX code field).

Ports:
- clk  in  1  frame clock; one frame slot per cycle.
- rst  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  PAYLOAD_WIDTH  user payload.
- s_axis_tkeep  in  PAYLOAD_WIDTH/8  byte enables.
- s_axis_tlast  in  1  end of packet.
- s_axis_tvalid  in  1  payload valid.
- s_axis_tready  out  1  payload accepted this cycle.
- rx_up  in  1  local receiver up.
- rx_error  in  1  level; local receiver saw a bad frame.
- rx_expected_id  in  FRAME_ID_WIDTH  next id the local receiver needs.
- retrans_req  in  1  pulse; remote asks us to replay.
- retrans_id  in  FRAME_ID_WIDTH  first id to replay.
- ack_valid  in  1  pulse; remote acknowledges frames.
- ack_id  in  FRAME_ID_WIDTH  all ids before ack_id are acknowledged.
- pause_req  in  1  level; remote asks us to stop DATA.
- local_fc  in  1  level; local RX buffer above threshold.
- remote_fc  in  1  level; remote RX buffer above threshold.
- frame_code  out  CODE_WIDTH  type of the current frame.
- frame_id  out  FRAME_ID_WIDTH  sequence id; valid for DATA frames.
- frame_payload  out  PAYLOAD_WIDTH  payload; for RETRANS frames, the low FRAME_ID_WIDTH bits carry rx_expected_id.
- frame_keep  out  PAYLOAD_WIDTH/8  byte enables for the frame.
- frame_last  out  1  end-of-packet flag for the frame.
- retrans_bad  out  1  pulse; retrans_id was outside the window.

Behaviour:
- Reset (rst low): frame_code=CODE_INIT; all other outputs 0; wr_ptr=ack_ptr=rd_ptr=0; state INIT.
- Pointers: wr_ptr, ack_ptr and rd_ptr are FRAME_ID_WIDTH+1 bits (wrap bit); compare on the low bits only.
  - count = wr_ptr - ack_ptr.
  - full = (count == 2**FRAME_ID_WIDTH).
- All frame_* outputs are registered.
- Latency: an s_axis beat accepted in cycle N appears on frame_* in cycle N+1.
- States: INIT, NORMAL, REPLAY.
  - INIT: emit CODE_INIT every cycle; tready=0. When rx_up=1, go to NORMAL, or to REPLAY if count!=0.
  - Any state: rx_up falling moves to INIT next cycle and sets rd_ptr=ack_ptr, so unacked frames replay after relink.
- Slot priority (NORMAL/REPLAY, first match wins):
  1. rx_error rising edge -> one CODE_RETRANS frame carrying rx_expected_id; a sustained level does not repeat it.
  2. local_fc edge -> one CODE_PAUSE frame on rise, one CODE_RESUME frame on fall.
  3. pause_req or remote_fc -> CODE_IDLE.
  4. REPLAY -> CODE_DATA from buffer[rd_ptr], frame_id=rd_ptr; rd_ptr++. When rd_ptr+1==wr_ptr, go to NORMAL.
  5. NORMAL and s_axis_tvalid and !full -> tready=1; write buffer[wr_ptr]; CODE_DATA with frame_id=wr_ptr; wr_ptr++.
  6. Otherwise CODE_IDLE.
- s_axis_tready is combinational:
  - 1 only when state=NORMAL, !full, and priorities 1-3 are not active;
  - never depends on tvalid.
- retrans_req:
  - accepted when (retrans_id - ack_ptr) mod 2**FRAME_ID_WIDTH < count; sets rd_ptr and enters REPLAY next cycle.
  - In REPLAY, a new request restarts replay from the new id.
  - Out of window: ignored, and retrans_bad pulses one cycle.
- ack_valid:
  - ack_ptr advances to ack_id when (ack_id - ack_ptr) mod 2**FRAME_ID_WIDTH <= count; otherwise ignored.
  - Same cycle as a write: full is evaluated on the pre-update count.
  - If ack passes rd_ptr during REPLAY, rd_ptr is clamped to ack_ptr.
- retrans_req and ack_valid in the same cycle: apply the ack first, then validate retrans_id against the new window.
- Buffer reads are asynchronous (LUTRAM).
- Write and replay-read to the same address in one cycle cannot occur, because REPLAY blocks writes.

Decomposition:
- Package rifl_tx_pkg holds:
  - CODE_INIT=18'h2AAAA, CODE_IDLE=18'h15555, CODE_DATA=18'h3C3C3, CODE_PAUSE=18'h0F0F0, CODE_RESUME=18'h30F0F, CODE_RETRANS=18'h03FFC (pairwise Hamming distance >= 6);
  - tx_state_t enum {INIT, NORMAL, REPLAY}.
- One sub-module, rifl_tx_replay_buf: dual-port RAM, depth 2**FRAME_ID_WIDTH, word {tlast, tkeep, tdata}, synchronous write, asynchronous read.

Test Plan:
- Reset, hold rx_up=0 for 10 cycles -> frame_code=CODE_INIT every cycle, tready=0. Raise rx_up -> first DATA frame has frame_id=0.
- Stream 300 beats with no acks, FRAME_ID_WIDTH=8 -> 256 accepted (ids 0..255), then tready=0 and CODE_IDLE. ack_id=16 -> tready reasserts; next frame_id=0 with wrap bit set.
- After ids 0..9 sent, with ack_ptr=2, pulse retrans_req with retrans_id=5 -> frames 5,6,7,8,9 replayed with the original payloads, then new data continues at id 10.
- retrans_id=20 while the window is 2..9 -> retrans_bad pulses one cycle; state and rd_ptr unchanged.
- local_fc rises during streaming -> exactly one CODE_PAUSE frame, tready=0 that cycle. rx_error rises in the same cycle -> RETRANS goes first, PAUSE follows next cycle.
- rx_up drops mid-replay at id 7 with ack_ptr=4 -> CODE_INIT frames. rx_up returns -> replay restarts at id 4.
